// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule definitions: FSM states, FK constants,
// S-box, the L' linear layer, T' and the arithmetic CK generator.
package sm4_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      READY  = 2'd2
   } state_t;

   localparam logic [31:0] FK0 = 32'ha3b1bac6;
   localparam logic [31:0] FK1 = 32'h56aa3350;
   localparam logic [31:0] FK2 = 32'h677d9197;
   localparam logic [31:0] FK3 = 32'hb27022dc;

   // Entry 0 sits in the top byte, so entry a starts at bit {~a,3'b111}.
   localparam logic [2047:0] SBOX = {
      128'hd690e9fecce13db716b614c228fb2c05,
      128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62,
      128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8,
      128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887,
      128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1,
      128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f,
      128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8,
      128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684,
      128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   function automatic logic [7:0] sbox(input logic [7:0] a);
      return SBOX[{~a, 3'b111} -: 8];
   endfunction

   function automatic logic [31:0] l_prime(input logic [31:0] b);
      return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
   endfunction

   function automatic logic [31:0] t_prime(input logic [31:0] x);
      return l_prime({sbox(x[31:24]), sbox(x[23:16]),
                      sbox(x[15:8]),  sbox(x[7:0])});
   endfunction

   function automatic logic [31:0] ck_word(input logic [4:0] i);
      logic [7:0]  b;
      logic [31:0] w;
      w = '0;
      for (int j = 0; j < 4; j++) begin
         b = ({3'b000, i} << 2) + 8'(j);
         b = b * 8'd7;
         w = {w[23:0], b};
      end
      return w;
   endfunction

endpackage

// File: rtl/sm4_key_schedule_if.sv
// User-key valid/ready channel into the SM4 key-schedule engine.
interface sm4_key_schedule_if;
   logic         key_valid_in;
   logic         key_ready_out;
   logic [127:0] key_in;

   modport master (
      output key_valid_in,
      output key_in,
      input  key_ready_out
   );

   modport slave (
      input  key_valid_in,
      input  key_in,
      output key_ready_out
   );
endinterface

// File: rtl/sm4_key_round.sv
// One combinational SM4 key-expansion round: derives rk_i from the
// 128-bit state and shifts it into the low word of the next state.
module sm4_key_round
   import sm4_pkg::*;
(
   input  logic [127:0] state,
   input  logic [4:0]   idx,
   output logic [127:0] state_nxt,
   output logic [31:0]  rk
);

   logic [31:0] k0, k1, k2, k3;

   assign {k0, k1, k2, k3} = state;
   assign rk        = k0 ^ t_prime(k1 ^ k2 ^ k3 ^ ck_word(idx));
   assign state_nxt = {k1, k2, k3, rk};

endmodule

// File: rtl/sm4_key_schedule.sv
// SM4 key-schedule engine: unrolled round chain, 32-entry round-key
// file and a registered read port with encrypt/decrypt ordering.
module sm4_key_schedule
   import sm4_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   sm4_key_schedule_if.slave   key_if,
   input  logic [4:0]          rd_idx_in,
   input  logic                decrypt_in,
   output logic [31:0]         rk_out,
   output logic                busy_out,
   output logic                done_out,
   output logic                keys_valid_out
);

   localparam int R = ROUNDS_PER_CYCLE;

   state_t       fsm;
   logic [5:0]   cnt;
   logic [5:0]   cnt_nxt;
   logic [127:0] st;
   logic         hs;
   logic [127:0] chain [R+1];
   logic [31:0]  rks [R];
   logic [31:0]  rf [32];

   assign key_if.key_ready_out = ~busy_out;
   assign hs      = key_if.key_valid_in & ~busy_out;
   assign cnt_nxt = cnt + 6'(R);
   assign chain[0] = st;

   for (genvar g = 0; g < R; g++) begin : g_rnd
      sm4_key_round u_rnd (
         .state     (chain[g]),
         .idx       (cnt[4:0] + 5'(g)),
         .state_nxt (chain[g+1]),
         .rk        (rks[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm            <= IDLE;
         cnt            <= '0;
         st             <= '0;
         busy_out       <= 1'b0;
         done_out       <= 1'b0;
         keys_valid_out <= 1'b0;
      end else begin
         done_out <= 1'b0;
         case (fsm)
            IDLE, READY: begin
               if (hs) begin
                  fsm            <= EXPAND;
                  busy_out       <= 1'b1;
                  keys_valid_out <= 1'b0;
                  cnt            <= '0;
                  st <= key_if.key_in ^ {FK0, FK1, FK2, FK3};
               end
            end
            EXPAND: begin
               st  <= chain[R];
               cnt <= cnt_nxt;
               if (cnt_nxt == 6'd32) begin
                  fsm            <= READY;
                  busy_out       <= 1'b0;
                  done_out       <= 1'b1;
                  keys_valid_out <= 1'b1;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

   // Key storage survives reset; only the valid flag says it is usable.
   always_ff @(posedge clk) begin
      if (fsm == EXPAND) begin
         for (int g = 0; g < R; g++)
            rf[cnt[4:0] + 5'(g)] <= rks[g];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rk_out <= '0;
      else
         rk_out <= rf[decrypt_in ? ~rd_idx_in : rd_idx_in];
   end

endmodule
